// File: rtl/instr_fetch_ctrl_if.sv
// instr_fetch_ctrl_if: control, memory-bus and shift-register signals of the fetch sequencer.
// The master modport is the sequencer side; slave is the environment driving it.
interface instr_fetch_ctrl_if;
    logic        start;
    logic [15:0] pc;
    logic        halt;
    logic [7:0]  bus_out;
    logic        bus_out_valid;
    logic        bus_out_ready;
    logic [7:0]  bus_in;
    logic        bus_in_valid;
    logic [7:0]  fetch_byte;
    logic        fetch_byte_valid;
    logic        done;
    logic [15:0] pc_next;
    logic        busy;
    logic        halted;
    logic        error;
    modport master (
        input  start, pc, halt, bus_out_ready, bus_in, bus_in_valid,
        output bus_out, bus_out_valid, fetch_byte, fetch_byte_valid, done, pc_next, busy, halted, error
    );
    modport slave (
        output start, pc, halt, bus_out_ready, bus_in, bus_in_valid,
        input  bus_out, bus_out_valid, fetch_byte, fetch_byte_valid, done, pc_next, busy, halted, error
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: sends the PC byte-serially, forwards 2 or 4 instruction bytes, reports next PC.
module instr_fetch_ctrl #(
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic rst,
    instr_fetch_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, ADDR_LO, ADDR_HI, WAIT_BYTE, DONE, HALTED, ERROR} state_t;
    typedef enum logic [2:0] {R_TYPE = 3'd0, I_TYPE = 3'd1, M_TYPE = 3'd2, B_TYPE = 3'd3, J_TYPE = 3'd4} opcode_t;
    state_t      r_state;
    logic [15:0] r_addr;
    logic [2:0]  r_cnt;
    logic [2:0]  r_need;
    logic [7:0]  r_timer;
    logic [7:0]  r_fetch_byte;
    logic        r_fetch_valid;
    logic        r_done;
    logic [15:0] r_pc_next;
    opcode_t     w_op;
    logic [2:0]  w_need;
    assign w_op   = opcode_t'(bus.bus_in[2:0]);
    // Length is fixed by the first byte only; later bytes keep the decided length.
    assign w_need = (r_cnt == 3'd0 && (w_op == I_TYPE || w_op == M_TYPE)) ? 3'd4 : r_need;
    assign bus.bus_out_valid    = r_state == ADDR_LO || r_state == ADDR_HI;
    assign bus.bus_out          = r_state == ADDR_LO ? r_addr[7:0] : r_state == ADDR_HI ? r_addr[15:8] : 8'd0;
    assign bus.fetch_byte       = r_fetch_byte;
    assign bus.fetch_byte_valid = r_fetch_valid;
    assign bus.done             = r_done;
    assign bus.pc_next          = r_pc_next;
    assign bus.busy             = r_state == ADDR_LO || r_state == ADDR_HI || r_state == WAIT_BYTE || r_state == DONE;
    assign bus.halted           = r_state == HALTED;
    assign bus.error            = r_state == ERROR;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_cnt         <= '0;
            r_need        <= '0;
            r_timer       <= '0;
            r_fetch_byte  <= '0;
            r_fetch_valid <= 1'b0;
            r_done        <= 1'b0;
            r_pc_next     <= '0;
        end else begin
            r_fetch_valid <= 1'b0;
            r_done        <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.halt) begin
                        r_state <= HALTED;
                    end else if (bus.start) begin
                        r_addr  <= bus.pc;
                        r_cnt   <= '0;
                        r_need  <= 3'd2;
                        r_timer <= '0;
                        r_state <= ADDR_LO;
                    end
                end
                ADDR_LO: r_state <= bus.bus_out_ready ? ADDR_HI : ADDR_LO;
                ADDR_HI: r_state <= bus.bus_out_ready ? WAIT_BYTE : ADDR_HI;
                WAIT_BYTE: begin
                    if (bus.bus_in_valid) begin
                        r_fetch_byte  <= bus.bus_in;
                        r_fetch_valid <= 1'b1;
                        r_cnt         <= r_cnt + 3'd1;
                        r_need        <= w_need;
                        r_timer       <= '0;
                        if (r_cnt + 3'd1 == w_need) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end else if (r_timer == 8'(TIMEOUT - 1)) begin
                        r_state <= ERROR;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                DONE: begin
                    r_pc_next <= r_addr + {13'd0, r_need};
                    r_state   <= IDLE;
                end
                default: r_state <= r_state;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: randomized fetches checked against a length/address model of the sequencer.
module tb_instr_fetch_ctrl;
    localparam int TO = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [7:0] q_addr[$];
    logic [7:0] q_strobe[$];
    int n_done = 0;
    instr_fetch_ctrl_if bus ();
    instr_fetch_ctrl #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (bus.bus_out_valid && bus.bus_out_ready) q_addr.push_back(bus.bus_out);
        if (bus.fetch_byte_valid) q_strobe.push_back(bus.fetch_byte);
        if (bus.done) n_done++;
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic clear();
        q_addr.delete();
        q_strobe.delete();
        n_done = 0;
    endtask
    function automatic int len_of(input logic [7:0] b);
        return (b[2:0] == 3'd1 || b[2:0] == 3'd2) ? 4 : 2;
    endfunction
    task automatic do_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.halt = 1'b0;
        bus.pc = '0;
        bus.bus_out_ready = 1'b1;
        bus.bus_in = '0;
        bus.bus_in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask
    task automatic check_idle_outputs(input string name);
        checks++;
        if ({bus.bus_out, bus.bus_out_valid, bus.fetch_byte, bus.fetch_byte_valid, bus.done,
             bus.pc_next, bus.busy, bus.halted, bus.error} !== '0) begin
            errors++;
            $display("FAIL %s: outputs bo=%h bov=%b fb=%h fbv=%b done=%b pcn=%h busy=%b halted=%b err=%b, required all zero",
                     name, bus.bus_out, bus.bus_out_valid, bus.fetch_byte, bus.fetch_byte_valid, bus.done,
                     bus.pc_next, bus.busy, bus.halted, bus.error);
        end
    endtask
    task automatic start_fetch(input logic [15:0] a);
        bus.pc = a;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask
    task automatic wait_addr(input string name);
        int n = 0;
        while (q_addr.size() < 2 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (q_addr.size() != 2) begin
            errors++;
            $display("FAIL %s_addr_count: got %0d address bytes, required 2", name, q_addr.size());
        end
    endtask
    task automatic send_byte(input logic [7:0] v, input int gap);
        repeat (gap) tick();
        bus.bus_in = v;
        bus.bus_in_valid = 1'b1;
        tick();
        bus.bus_in_valid = 1'b0;
    endtask
    task automatic do_fetch(input string name, input logic [15:0] a, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input int gmin, input int gmax, input int hold);
        logic [7:0] b[4];
        logic [15:0] exp_pc;
        int n;
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        n = len_of(b0);
        exp_pc = a + 16'(n);
        clear();
        bus.bus_out_ready = (hold == 0);
        start_fetch(a);
        for (int i = 0; i < hold; i++) begin
            checks++;
            if (bus.bus_out !== a[7:0] || bus.bus_out_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s_hold%0d: bus_out=%h valid=%b, required %h valid=1", name, i, bus.bus_out, bus.bus_out_valid, a[7:0]);
            end
            tick();
        end
        bus.bus_out_ready = 1'b1;
        wait_addr(name);
        if (q_addr.size() == 2) begin
            checks++;
            if (q_addr[0] !== a[7:0] || q_addr[1] !== a[15:8]) begin
                errors++;
                $display("FAIL %s_addr: got %h %h, required %h %h", name, q_addr[0], q_addr[1], a[7:0], a[15:8]);
            end
        end
        for (int k = 0; k < 4; k++) send_byte(b[k], int'($urandom_range(gmax, gmin)));
        repeat (3) tick();
        checks++;
        if (q_strobe.size() != n) begin
            errors++;
            $display("FAIL %s_strobes: got %0d strobes, required %0d", name, q_strobe.size(), n);
        end
        for (int k = 0; k < n && k < q_strobe.size(); k++) begin
            checks++;
            if (q_strobe[k] !== b[k]) begin
                errors++;
                $display("FAIL %s_byte%0d: got %h, required %h", name, k, q_strobe[k], b[k]);
            end
        end
        checks++;
        if (n_done != 1) begin
            errors++;
            $display("FAIL %s_done: got %0d pulses, required 1", name, n_done);
        end
        checks++;
        if (bus.pc_next !== exp_pc || bus.busy !== 1'b0 || bus.error !== 1'b0) begin
            errors++;
            $display("FAIL %s_pc_next: got %h busy=%b err=%b, required %h busy=0 err=0", name, bus.pc_next, bus.busy, bus.error, exp_pc);
        end
    endtask
    task automatic test_reset();
        do_reset();
        check_idle_outputs("reset");
    endtask
    task automatic test_two_byte();
        do_fetch("two_byte", 16'h0010, 8'h00, 8'h12, 8'hAA, 8'hBB, 0, 0, 0);
    endtask
    task automatic test_four_byte();
        do_fetch("four_byte", 16'h1234, 8'h41, 8'h22, 8'h33, 8'h44, 3, 3, 0);
    endtask
    task automatic test_backpressure();
        do_fetch("backpressure", 16'h1234, 8'h08, 8'h5A, 8'h11, 8'h22, 0, 1, 5);
    endtask
    task automatic test_wrap();
        do_fetch("wrap_m", 16'hFFFE, 8'h02, 8'h10, 8'h20, 8'h30, 0, 2, 0);
        do_fetch("wrap_r", 16'hFFFE, 8'h00, 8'h77, 8'h88, 8'h99, 0, 2, 0);
    endtask
    task automatic test_random();
        for (int t = 0; t < 12; t++)
            do_fetch($sformatf("rand%0d", t), 16'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                     0, 5, int'($urandom_range(2, 0)));
    endtask
    task automatic test_timeout();
        clear();
        start_fetch(16'h2000);
        wait_addr("timeout");
        send_byte(8'h01, 0);
        repeat (TO - 1) tick();
        checks++;
        if (bus.error !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: err=%b busy=%b after %0d idle cycles, required err=0 busy=1", bus.error, bus.busy, TO - 1);
        end
        tick();
        checks++;
        if (bus.error !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flag: err=%b busy=%b after %0d idle cycles, required err=1 busy=0", bus.error, bus.busy, TO);
        end
        clear();
        start_fetch(16'h3000);
        for (int k = 0; k < 4; k++) send_byte(8'($urandom), 1);
        checks++;
        if (q_addr.size() != 0 || q_strobe.size() != 0 || n_done != 0 || bus.error !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: addr=%0d strobes=%0d done=%0d err=%b, required 0 0 0 1",
                     q_addr.size(), q_strobe.size(), n_done, bus.error);
        end
        do_reset();
        check_idle_outputs("timeout_reset");
    endtask
    task automatic test_halt();
        clear();
        bus.halt = 1'b1;
        bus.pc = 16'h1111;
        bus.start = 1'b1;
        tick();
        bus.halt = 1'b0;
        bus.start = 1'b0;
        checks++;
        if (bus.halted !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL halt_priority: halted=%b busy=%b, required halted=1 busy=0", bus.halted, bus.busy);
        end
        start_fetch(16'h2222);
        for (int k = 0; k < 3; k++) send_byte(8'h01, 0);
        checks++;
        if (q_addr.size() != 0 || q_strobe.size() != 0 || bus.halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_ignore: addr=%0d strobes=%0d halted=%b, required 0 0 1", q_addr.size(), q_strobe.size(), bus.halted);
        end
        do_reset();
        check_idle_outputs("halt_reset");
    endtask
    task automatic test_reset_mid();
        clear();
        start_fetch(16'h5555);
        wait_addr("reset_mid");
        send_byte(8'h01, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.bus_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle: busy=%b bov=%b, required 0 0", bus.busy, bus.bus_out_valid);
        end
        repeat (3) tick();
        checks++;
        if (n_done != 0 || q_strobe.size() != 1) begin
            errors++;
            $display("FAIL reset_mid_done: done=%0d strobes=%0d, required 0 1", n_done, q_strobe.size());
        end
        do_fetch("after_reset", 16'h0100, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 0, 1, 0);
    endtask
    initial begin
        test_reset();
        test_two_byte();
        test_four_byte();
        test_backpressure();
        test_wrap();
        test_random();
        test_timeout();
        test_halt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Byte-serial fetch sequencer that sits directly upstream of the instruction shift register. On a start request it sends the 16-bit PC to memory over the 8-bit bus, low byte first. It then collects the returned instruction bytes and forwards each one as a one-cycle strobe, which drives the shift register's data_ready/serial_in. It decides the instruction length from the first byte, reports completion with the next PC, and flags a memory timeout.

Parameters:
TIMEOUT, 255, max consecutive WAIT_BYTE cycles without bus_in_valid before error (1..255)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  begin fetch at pc; honoured only in IDLE
pc  input  16  fetch address, sampled on accepted start
halt  input  1  halt from shift register; honoured only in IDLE
bus_out  output  8  address byte to memory
bus_out_valid  output  1  bus_out holds a valid address byte
bus_out_ready  input  1  memory accepts bus_out this cycle
bus_in  input  8  instruction byte from memory
bus_in_valid  input  1  bus_in valid this cycle
fetch_byte  output  8  byte to shift register serial_in
fetch_byte_valid  output  1  one-cycle strobe to shift register data_ready
done  output  1  one-cycle pulse, instruction fully delivered
pc_next  output  16  address following fetched instruction
busy  output  1  state not IDLE/HALTED/ERROR
halted  output  1  in HALTED
error  output  1  sticky timeout flag

Behaviour:
- Reset: state=IDLE. All outputs 0: bus_out, bus_out_valid, fetch_byte, fetch_byte_valid, done, pc_next, busy, halted, error. Internal addr_q, byte_cnt, need and timer also clear to 0. Reset overrides every state, including mid-fetch.
- States: IDLE, ADDR_LO, ADDR_HI, WAIT_BYTE, DONE, HALTED, ERROR.
- IDLE:
  - halt=1 -> HALTED; halt has priority over start.
  - Otherwise start=1 -> addr_q<=pc, byte_cnt<=0, need<=2, timer<=0, go to ADDR_LO.
- ADDR_LO: bus_out=addr_q[7:0], bus_out_valid=1. Stay until bus_out_ready=1, then go to ADDR_HI.
- ADDR_HI: bus_out=addr_q[15:8], bus_out_valid=1. On bus_out_ready go to WAIT_BYTE.
- bus_out_valid is combinational from state; bus_out=0 in all other states.
- WAIT_BYTE, cycle with bus_in_valid=1:
  - fetch_byte<=bus_in and fetch_byte_valid<=1 on the next cycle (latency 1, registered).
  - byte_cnt<=byte_cnt+1, timer<=0.
  - If byte_cnt==0 and bus_in[2:0] is opcode_t I_TYPE or M_TYPE, need<=4; otherwise need stays 2.
  - If byte_cnt+1 == need (using the need value decided this cycle), go to DONE.
- WAIT_BYTE, cycle with bus_in_valid=0: timer<=timer+1. When timer reaches TIMEOUT-1, go to ERROR.
- fetch_byte_valid is high for exactly one cycle per accepted byte. fetch_byte holds its last value otherwise.
- DONE, one cycle:
  - done=1 (registered pulse).
  - pc_next<=addr_q+need, modulo 2^16 (0xFFFE+2 wraps to 0x0000).
  - Return to IDLE. A start in the DONE cycle is ignored.
- HALTED: halted=1. Ignore start and bus inputs until rst.
- ERROR: error=1. Ignore all inputs until rst. bus_out_valid=0.
- bus_in_valid outside WAIT_BYTE is ignored and produces no strobe. start outside IDLE is ignored.
- busy=1 in ADDR_LO, ADDR_HI, WAIT_BYTE and DONE.
- Total bytes forwarded per fetch is exactly 2 or 4. pc_next keeps its value until the next DONE.

Test Plan:
- 2-byte fetch: rst; start with pc=0x0010; memory ready immediately; return bytes 0x00, 0x12 (R_TYPE) -> bus_out=0x10 then 0x00. Two fetch_byte_valid strobes carry 0x00 and 0x12. done pulses once; pc_next=0x0012.
- 4-byte fetch: pc=0x1234; first byte has opcode I_TYPE; bytes B1..B4 arrive with gaps of 3 idle cycles -> exactly 4 strobes in order; done pulses; pc_next=0x1238.
- Address backpressure: bus_out_ready low for 5 cycles in ADDR_LO -> bus_out holds 0x34 with valid=1 throughout; no advance until ready.
- Wrap-around: pc=0xFFFE, M_TYPE fetch -> pc_next=0x0002. Then pc=0xFFFE, R_TYPE fetch -> pc_next=0x0000.
- Timeout: TIMEOUT=8; after the first byte, no bus_in_valid for 8 cycles -> error=1, busy=0. Later start and bytes are ignored until rst, after which all outputs are 0.
- Halt/priority/reset: halt and start together in IDLE -> halted=1, no bus activity. rst asserted mid-WAIT_BYTE -> IDLE next cycle, no done, fresh fetch works.
